id_ex_register: RTL and testbench

ID/EX pipeline register for the 16-bit pipelined MIPS core. It sits directly downstream of the decode-stage control unit and register file. Each cycle it captures the decoded control bundle, operands and register fields, and presents them to the EX stage one cycle later. It also holds the load-use hazard detector, inserts bubbles, honours external stall and flush, and keeps a saturating bubble counter for performance debug.

---
 rtl/id_ex_register_if.sv | 69 ++++++
 rtl/id_ex_register.sv | 120 ++++++++++++
 tb/tb_id_ex_register.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_register_if.sv
// ID/EX boundary bundle: decoded controls, operands and register fields from ID,
// their registered copies toward EX, plus hazard and bubble-count observability.
//   master : ID-side driver (controls/operands/fields, stall, flush, valid)
//   slave  : the ID/EX register itself
interface id_ex_register_if #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned REG_ADDR_WIDTH = 3,
  parameter int unsigned CNT_WIDTH      = 8
);
  logic                      i_Stall;
  logic                      i_Flush;
  logic                      i_ID_Valid;
  logic                      i_Sig_RegDst;
  logic                      i_Sig_ALUSrc;
  logic                      i_Sig_MemtoReg;
  logic                      i_Sig_RegWrite;
  logic                      i_Sig_MemRead;
  logic                      i_Sig_MemWrite;
  logic                      i_Sig_Branch;
  logic [1:0]                i_Sigs_ALUOp;
  logic [DATA_WIDTH-1:0]     i_Read_Data1;
  logic [DATA_WIDTH-1:0]     i_Read_Data2;
  logic [DATA_WIDTH-1:0]     i_Imm_Ext;
  logic [DATA_WIDTH-1:0]     i_PC_Next;
  logic [REG_ADDR_WIDTH-1:0] i_Rs;
  logic [REG_ADDR_WIDTH-1:0] i_Rt;
  logic [REG_ADDR_WIDTH-1:0] i_Rd;

  logic                      o_Sig_RegDst;
  logic                      o_Sig_ALUSrc;
  logic                      o_Sig_MemtoReg;
  logic                      o_Sig_RegWrite;
  logic                      o_Sig_MemRead;
  logic                      o_Sig_MemWrite;
  logic                      o_Sig_Branch;
  logic [1:0]                o_Sigs_ALUOp;
  logic [DATA_WIDTH-1:0]     o_Read_Data1;
  logic [DATA_WIDTH-1:0]     o_Read_Data2;
  logic [DATA_WIDTH-1:0]     o_Imm_Ext;
  logic [DATA_WIDTH-1:0]     o_PC_Next;
  logic [REG_ADDR_WIDTH-1:0] o_Rs;
  logic [REG_ADDR_WIDTH-1:0] o_Rt;
  logic [REG_ADDR_WIDTH-1:0] o_Rd;
  logic                      o_Valid;
  logic                      o_Hazard_Stall;
  logic [CNT_WIDTH-1:0]      o_Bubble_Count;

  modport master (
    output i_Stall, i_Flush, i_ID_Valid,
           i_Sig_RegDst, i_Sig_ALUSrc, i_Sig_MemtoReg, i_Sig_RegWrite,
           i_Sig_MemRead, i_Sig_MemWrite, i_Sig_Branch, i_Sigs_ALUOp,
           i_Read_Data1, i_Read_Data2, i_Imm_Ext, i_PC_Next, i_Rs, i_Rt, i_Rd,
    input  o_Sig_RegDst, o_Sig_ALUSrc, o_Sig_MemtoReg, o_Sig_RegWrite,
           o_Sig_MemRead, o_Sig_MemWrite, o_Sig_Branch, o_Sigs_ALUOp,
           o_Read_Data1, o_Read_Data2, o_Imm_Ext, o_PC_Next, o_Rs, o_Rt, o_Rd,
           o_Valid, o_Hazard_Stall, o_Bubble_Count
  );

  modport slave (
    input  i_Stall, i_Flush, i_ID_Valid,
           i_Sig_RegDst, i_Sig_ALUSrc, i_Sig_MemtoReg, i_Sig_RegWrite,
           i_Sig_MemRead, i_Sig_MemWrite, i_Sig_Branch, i_Sigs_ALUOp,
           i_Read_Data1, i_Read_Data2, i_Imm_Ext, i_PC_Next, i_Rs, i_Rt, i_Rd,
    output o_Sig_RegDst, o_Sig_ALUSrc, o_Sig_MemtoReg, o_Sig_RegWrite,
           o_Sig_MemRead, o_Sig_MemWrite, o_Sig_Branch, o_Sigs_ALUOp,
           o_Read_Data1, o_Read_Data2, o_Imm_Ext, o_PC_Next, o_Rs, o_Rt, o_Rd,
           o_Valid, o_Hazard_Stall, o_Bubble_Count
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// stall/flush handling and a saturating bubble counter.
//   i_Clk     : rising-edge clock
//   i_Reset_n : asynchronous active-low reset, clears all contents to a bubble
//   bus       : slave side of id_ex_register_if (ID inputs, EX outputs,
//               combinational o_Hazard_Stall, o_Bubble_Count)
module id_ex_register #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned REG_ADDR_WIDTH = 3,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  id_ex_register_if.slave        bus
);

  typedef struct packed {
    logic                      valid;
    logic                      reg_dst;
    logic                      alu_src;
    logic                      memto_reg;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      branch;
    logic [1:0]                alu_op;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pc;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } stage_t;

  stage_t               r_stage;
  stage_t               w_stage_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_hazard;
  logic                 w_bubble;

  // Load in EX whose destination (rt) is a source of the real ID instruction
  assign w_hazard = r_stage.valid & r_stage.mem_read & bus.i_ID_Valid &
                    (r_stage.rt != '0) &
                    ((r_stage.rt == bus.i_Rs) | (r_stage.rt == bus.i_Rt));

  // A flush squashes the ID instruction, so its hazard is irrelevant
  assign bus.o_Hazard_Stall = w_hazard & ~bus.i_Flush;

  // Next contents: flush > stall(hold) > hazard bubble > ID capture
  always_comb begin
    w_stage_next = r_stage;
    w_bubble     = 1'b0;
    if (bus.i_Flush) begin
      w_stage_next = '0;
      w_bubble     = 1'b1;
    end else if (bus.i_Stall) begin
      w_stage_next = r_stage;
    end else if (w_hazard) begin
      w_stage_next = '0;
      w_bubble     = 1'b1;
    end else begin
      // Invalid ID slots carry data/fields but never controls
      w_stage_next.valid     = bus.i_ID_Valid;
      w_stage_next.reg_dst   = bus.i_Sig_RegDst   & bus.i_ID_Valid;
      w_stage_next.alu_src   = bus.i_Sig_ALUSrc   & bus.i_ID_Valid;
      w_stage_next.memto_reg = bus.i_Sig_MemtoReg & bus.i_ID_Valid;
      w_stage_next.reg_write = bus.i_Sig_RegWrite & bus.i_ID_Valid;
      w_stage_next.mem_read  = bus.i_Sig_MemRead  & bus.i_ID_Valid;
      w_stage_next.mem_write = bus.i_Sig_MemWrite & bus.i_ID_Valid;
      w_stage_next.branch    = bus.i_Sig_Branch   & bus.i_ID_Valid;
      w_stage_next.alu_op    = bus.i_ID_Valid ? bus.i_Sigs_ALUOp : 2'b00;
      w_stage_next.rd1       = bus.i_Read_Data1;
      w_stage_next.rd2       = bus.i_Read_Data2;
      w_stage_next.imm       = bus.i_Imm_Ext;
      w_stage_next.pc        = bus.i_PC_Next;
      w_stage_next.rs        = bus.i_Rs;
      w_stage_next.rt        = bus.i_Rt;
      w_stage_next.rd        = bus.i_Rd;
    end
  end

  // Saturating bubble counter
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_bubble && (r_cnt != '1)) begin
      w_cnt_next = r_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_stage <= '0;
      r_cnt   <= '0;
    end else begin
      r_stage <= w_stage_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign bus.o_Valid        = r_stage.valid;
  assign bus.o_Sig_RegDst   = r_stage.reg_dst;
  assign bus.o_Sig_ALUSrc   = r_stage.alu_src;
  assign bus.o_Sig_MemtoReg = r_stage.memto_reg;
  assign bus.o_Sig_RegWrite = r_stage.reg_write;
  assign bus.o_Sig_MemRead  = r_stage.mem_read;
  assign bus.o_Sig_MemWrite = r_stage.mem_write;
  assign bus.o_Sig_Branch   = r_stage.branch;
  assign bus.o_Sigs_ALUOp   = r_stage.alu_op;
  assign bus.o_Read_Data1   = r_stage.rd1;
  assign bus.o_Read_Data2   = r_stage.rd2;
  assign bus.o_Imm_Ext      = r_stage.imm;
  assign bus.o_PC_Next      = r_stage.pc;
  assign bus.o_Rs           = r_stage.rs;
  assign bus.o_Rt           = r_stage.rt;
  assign bus.o_Rd           = r_stage.rd;
  assign bus.o_Bubble_Count = r_cnt;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed testbench for id_ex_register.
module tb_id_ex_register;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;
  localparam int unsigned CW = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  id_ex_register_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) bus ();

  id_ex_register #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .i_Clk     (clk),
    .i_Reset_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_Stall        = 1'b0;
    bus.i_Flush        = 1'b0;
    bus.i_ID_Valid     = 1'b0;
    bus.i_Sig_RegDst   = 1'b0;
    bus.i_Sig_ALUSrc   = 1'b0;
    bus.i_Sig_MemtoReg = 1'b0;
    bus.i_Sig_RegWrite = 1'b0;
    bus.i_Sig_MemRead  = 1'b0;
    bus.i_Sig_MemWrite = 1'b0;
    bus.i_Sig_Branch   = 1'b0;
    bus.i_Sigs_ALUOp   = 2'b00;
    bus.i_Read_Data1   = '0;
    bus.i_Read_Data2   = '0;
    bus.i_Imm_Ext      = '0;
    bus.i_PC_Next      = '0;
    bus.i_Rs           = '0;
    bus.i_Rt           = '0;
    bus.i_Rd           = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();

    // Reset state
    #3;
    check("rst_valid", 32'(bus.o_Valid), 32'd0);
    check("rst_count", 32'(bus.o_Bubble_Count), 32'd0);
    check("rst_rd1",   32'(bus.o_Read_Data1), 32'd0);
    check("rst_hazard", 32'(bus.o_Hazard_Stall), 32'd0);
    #9 rst_n = 1'b1;

    // ALU op captured with one-cycle latency
    bus.i_ID_Valid = 1'b1; bus.i_Sig_RegWrite = 1'b1; bus.i_Sigs_ALUOp = 2'b00;
    bus.i_Read_Data1 = 16'h1234; bus.i_Rs = 3'd1; bus.i_Rt = 3'd2; bus.i_Rd = 3'd4;
    step();
    check("alu_regwrite", 32'(bus.o_Sig_RegWrite), 32'd1);
    check("alu_rd1",      32'(bus.o_Read_Data1), 32'h1234);
    check("alu_valid",    32'(bus.o_Valid), 32'd1);
    check("alu_rd",       32'(bus.o_Rd), 32'd4);
    check("alu_count",    32'(bus.o_Bubble_Count), 32'd0);

    // Load into EX with rt=3
    idle_inputs();
    bus.i_ID_Valid = 1'b1; bus.i_Sig_MemRead = 1'b1; bus.i_Sig_MemtoReg = 1'b1;
    bus.i_Sig_ALUSrc = 1'b1; bus.i_Sig_RegWrite = 1'b1; bus.i_Rs = 3'd1; bus.i_Rt = 3'd3;
    bus.i_Imm_Ext = 16'h0005;
    step();
    check("ld_memread", 32'(bus.o_Sig_MemRead), 32'd1);
    check("ld_rt",      32'(bus.o_Rt), 32'd3);

    // Dependent instruction: hazard, one bubble, then it loads
    idle_inputs();
    bus.i_ID_Valid = 1'b1; bus.i_Sig_RegWrite = 1'b1; bus.i_Sig_RegDst = 1'b1;
    bus.i_Sigs_ALUOp = 2'b10; bus.i_Read_Data1 = 16'hAAAA;
    bus.i_Rs = 3'd3; bus.i_Rt = 3'd5; bus.i_Rd = 3'd6;
    #1;
    check("lu_hazard", 32'(bus.o_Hazard_Stall), 32'd1);
    step();
    check("lu_bub_valid", 32'(bus.o_Valid), 32'd0);
    check("lu_bub_regwr", 32'(bus.o_Sig_RegWrite), 32'd0);
    check("lu_bub_memrd", 32'(bus.o_Sig_MemRead), 32'd0);
    check("lu_bub_aluop", 32'(bus.o_Sigs_ALUOp), 32'd0);
    check("lu_bub_rd1",   32'(bus.o_Read_Data1), 32'd0);
    check("lu_bub_count", 32'(bus.o_Bubble_Count), 32'd1);
    check("lu_bub_hazard", 32'(bus.o_Hazard_Stall), 32'd0);
    step();
    check("lu_load_valid", 32'(bus.o_Valid), 32'd1);
    check("lu_load_rd1",   32'(bus.o_Read_Data1), 32'hAAAA);
    check("lu_load_rs",    32'(bus.o_Rs), 32'd3);
    check("lu_load_aluop", 32'(bus.o_Sigs_ALUOp), 32'd2);
    check("lu_load_hazard", 32'(bus.o_Hazard_Stall), 32'd0);
    check("lu_load_count", 32'(bus.o_Bubble_Count), 32'd1);

    // No false hazard: load with rt=0 against rs=0
    idle_inputs();
    bus.i_ID_Valid = 1'b1; bus.i_Sig_MemRead = 1'b1; bus.i_Rs = 3'd1; bus.i_Rt = 3'd0;
    step();
    idle_inputs();
    bus.i_ID_Valid = 1'b1; bus.i_Rs = 3'd0; bus.i_Rt = 3'd0;
    #1;
    check("nofh_rt0", 32'(bus.o_Hazard_Stall), 32'd0);

    // No false hazard: non-load with rt=2 against rt=2
    idle_inputs();
    bus.i_ID_Valid = 1'b1; bus.i_Sig_RegWrite = 1'b1; bus.i_Rs = 3'd1; bus.i_Rt = 3'd2;
    step();
    idle_inputs();
    bus.i_ID_Valid = 1'b1; bus.i_Rs = 3'd7; bus.i_Rt = 3'd2;
    #1;
    check("nofh_nonload", 32'(bus.o_Hazard_Stall), 32'd0);

    // Invalid ID slot: data loads, controls zero
    idle_inputs();
    bus.i_ID_Valid = 1'b0; bus.i_Sig_RegWrite = 1'b1; bus.i_Sigs_ALUOp = 2'b11;
    bus.i_Read_Data1 = 16'h5555;
    step();
    check("inv_valid", 32'(bus.o_Valid), 32'd0);
    check("inv_regwr", 32'(bus.o_Sig_RegWrite), 32'd0);
    check("inv_aluop", 32'(bus.o_Sigs_ALUOp), 32'd0);
    check("inv_rd1",   32'(bus.o_Read_Data1), 32'h5555);
    check("inv_count", 32'(bus.o_Bubble_Count), 32'd1);

    // Stall holds for 3 cycles
    idle_inputs();
    bus.i_ID_Valid = 1'b1; bus.i_Sig_RegWrite = 1'b1; bus.i_Read_Data1 = 16'hBEEF; bus.i_Rt = 3'd2;
    step();
    check("pre_stall_rd1", 32'(bus.o_Read_Data1), 32'hBEEF);
    idle_inputs();
    bus.i_Stall = 1'b1; bus.i_ID_Valid = 1'b1; bus.i_Read_Data1 = 16'h0F0F;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rd1",   32'(bus.o_Read_Data1), 32'hBEEF);
      check("stall_valid", 32'(bus.o_Valid), 32'd1);
      check("stall_regwr", 32'(bus.o_Sig_RegWrite), 32'd1);
      check("stall_count", 32'(bus.o_Bubble_Count), 32'd1);
    end

    // Stall and flush together: flush wins
    bus.i_Flush = 1'b1;
    step();
    check("sf_valid", 32'(bus.o_Valid), 32'd0);
    check("sf_rd1",   32'(bus.o_Read_Data1), 32'd0);
    check("sf_count", 32'(bus.o_Bubble_Count), 32'd2);

    // Flush masks a pending hazard
    idle_inputs();
    bus.i_ID_Valid = 1'b1; bus.i_Sig_MemRead = 1'b1; bus.i_Rt = 3'd4;
    step();
    idle_inputs();
    bus.i_ID_Valid = 1'b1; bus.i_Rs = 3'd4; bus.i_Rt = 3'd1;
    #1;
    check("fh_hazard_on", 32'(bus.o_Hazard_Stall), 32'd1);
    bus.i_Flush = 1'b1;
    #1;
    check("fh_hazard_masked", 32'(bus.o_Hazard_Stall), 32'd0);
    step();
    check("fh_valid", 32'(bus.o_Valid), 32'd0);
    check("fh_count", 32'(bus.o_Bubble_Count), 32'd3);

    // Saturation: 3 + 252 = 255, then stays
    for (int i = 0; i < 251; i++) step();
    check("sat_fe", 32'(bus.o_Bubble_Count), 32'hFE);
    step();
    check("sat_ff", 32'(bus.o_Bubble_Count), 32'hFF);
    for (int i = 0; i < 8; i++) step();
    check("sat_hold", 32'(bus.o_Bubble_Count), 32'hFF);

    // Async reset between edges
    idle_inputs();
    bus.i_ID_Valid = 1'b1; bus.i_Sig_RegWrite = 1'b1; bus.i_Read_Data1 = 16'h1357; bus.i_Rd = 3'd7;
    step();
    check("pre_rst_valid", 32'(bus.o_Valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.o_Valid), 32'd0);
    check("arst_rd1",   32'(bus.o_Read_Data1), 32'd0);
    check("arst_regwr", 32'(bus.o_Sig_RegWrite), 32'd0);
    check("arst_rd",    32'(bus.o_Rd), 32'd0);
    check("arst_count", 32'(bus.o_Bubble_Count), 32'd0);
    #3 rst_n = 1'b1;
    step();
    check("post_rst_rd1",   32'(bus.o_Read_Data1), 32'h1357);
    check("post_rst_valid", 32'(bus.o_Valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
